// File: rtl/fetch_unit.sv
// RV32I fetch stage: drives the shared memory read port, absorbs its 1-cycle read latency
// and queues fetched words in a 2-entry FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_read_address,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data,
    input  logic        port_grant,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_pc_q [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    assign pop  = inst_valid & inst_ready;
    assign push = inflight_q & ~redirect;

    // Credit: entries held after this cycle plus the one this issue will return must fit.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = port_grant & ~redirect & ~fault_q & (occupancy < 3'd2);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        fault_d       = fault_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        head_d        = head_q ^ pop;
        tail_d        = tail_q ^ push;

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end

        // A pop in the redirect cycle still completes; the flush just discards the rest.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            fault_d    = |redirect_pc[1:0];
            inflight_d = 1'b0;
            count_d    = 2'd0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            fault_q       <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_inst_q[i] <= 32'h0;
                fifo_pc_q[i]   <= 32'h0;
            end
        end else if (push) begin
            fifo_inst_q[tail_q] <= mem_read_data;
            fifo_pc_q[tail_q]   <= inflight_pc_q;
        end
    end

    assign mem_read_address = fetch_pc_q;
    assign mem_funct3       = 3'b010;
    assign inst_valid       = (count_q != 2'd0);
    assign inst             = inst_valid ? fifo_inst_q[head_q] : 32'h0;
    assign inst_pc          = inst_valid ? fifo_pc_q[head_q] : 32'h0;
    assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random grant/ready/redirect/reset traffic,
// with delivered instructions checked against an expected sequential-PC stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_read_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;
    logic        port_grant;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [31:0] mem [1024];

    // Reference model: after a reset or aligned redirect the decode stream is P, P+4, P+8, ...
    logic [31:0] exp_q [$];
    logic [31:0] model_next;
    logic        model_fault;
    logic [31:0] exp_pc;

    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic [31:0] hold_addr;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_address (mem_read_address),
        .mem_funct3       (mem_funct3),
        .mem_read_data    (mem_read_data),
        .port_grant       (port_grant),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .fetch_fault      (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd4096) return mem[a[11:2]];
        return 32'h0;
    endfunction

    // Memory with a registered 1-cycle read
    always @(posedge clk) mem_read_data <= mem_word(mem_read_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_valid", inst_valid, 1'b0);
            exp_q.delete();
            model_next  = RESET_PC;
            model_fault = 1'b0;
        end else begin
            if (model_fault) begin
                chk1("fault_no_valid", inst_valid, 1'b0);
            end else if (inst_valid && inst_ready) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back(model_next);
                    model_next = model_next + 32'd4;
                end
                exp_pc = exp_q.pop_front();
                chk("sb_inst_pc", inst_pc, exp_pc);
                chk("sb_inst", inst, mem_word(exp_pc));
                pops++;
            end
            chk1("sb_fetch_fault", fetch_fault, model_fault);
            if (redirect) begin
                exp_q.delete();
                model_next  = redirect_pc;
                model_fault = |redirect_pc[1:0];
            end
        end
    end

    function automatic logic [31:0] pick_target();
        int sel;
        logic [31:0] r;
        sel = $urandom_range(0, 9);
        r   = $urandom;
        if (sel < 6) return {20'h0, r[11:2], 2'b00};
        if (sel < 8) return 32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3);
        return {20'h0, r[11:0]} | 32'h1;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;

        rst_n       = 1'b0;
        port_grant  = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_next  = RESET_PC;
        model_fault = 1'b0;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_fetch_fault", fetch_fault, 1'b0);
        chk("funct3", {29'h0, mem_funct3}, 32'h2);
        chk("rst_addr", mem_read_address, RESET_PC);
        next_cycle();
        rst_n = 1'b1;

        // 1: first fetch after reset and back-to-back stream
        @(negedge clk); chk1("c0_valid", inst_valid, 1'b0); chk("c0_addr", mem_read_address, 32'h0);
        next_cycle();
        @(negedge clk); chk1("c1_valid", inst_valid, 1'b0); chk("c1_addr", mem_read_address, 32'h4);
        next_cycle();
        @(negedge clk);
        chk1("c2_valid", inst_valid, 1'b1);
        chk("c2_inst", inst, 32'h0050_0093);
        chk("c2_pc", inst_pc, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("c3_inst", inst, 32'h0010_0113);
        chk("c3_pc", inst_pc, 32'h4);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk1("stream_valid", inst_valid, 1'b1);
            next_cycle();
        end

        // 2: decode stall, output held, issue stops
        for (int i = 0; i < 5; i++) begin
            inst_ready = 1'b0;
            @(negedge clk);
            if (i == 0) begin
                hold_pc   = inst_pc;
                hold_inst = inst;
            end else begin
                chk("stall_pc", inst_pc, hold_pc);
                chk("stall_inst", inst, hold_inst);
            end
            chk1("stall_valid", inst_valid, 1'b1);
            chk("stall_addr", mem_read_address, hold_pc + 32'd8);
            next_cycle();
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk1("resume_valid", inst_valid, 1'b1);
            next_cycle();
        end

        // 3: port lost to the load path
        port_grant = 1'b0;
        @(negedge clk); hold_addr = mem_read_address;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); chk("nogrant_addr", mem_read_address, hold_addr);
            next_cycle();
        end
        port_grant = 1'b1;
        repeat (6) next_cycle();

        // 4: redirect with FIFO filling and a read in flight
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        next_cycle();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        chk1("rd_t1_valid", inst_valid, 1'b0);
        chk("rd_t1_addr", mem_read_address, 32'h100);
        next_cycle();
        @(negedge clk); chk1("rd_t2_valid", inst_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rd_t3_valid", inst_valid, 1'b1);
        chk("rd_t3_pc", inst_pc, 32'h100);
        next_cycle();
        repeat (4) next_cycle();

        // 5: misaligned redirect faults, aligned redirect recovers
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk1("flt_set", fetch_fault, 1'b1);
        chk1("flt_valid", inst_valid, 1'b0);
        hold_addr = mem_read_address;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("flt_hold", fetch_fault, 1'b1);
            chk1("flt_hold_valid", inst_valid, 1'b0);
            chk("flt_no_issue", mem_read_address, hold_addr);
            next_cycle();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk); chk1("flt_clr", fetch_fault, 1'b0); chk1("clr_t1_valid", inst_valid, 1'b0);
        next_cycle();
        @(negedge clk); chk1("clr_t2_valid", inst_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("clr_t3_valid", inst_valid, 1'b1);
        chk("clr_t3_pc", inst_pc, 32'h200);
        chk("clr_t3_inst", inst, mem[32'h80]);
        next_cycle();
        repeat (4) next_cycle();

        // 6: asynchronous reset mid-stream, then wrap at the top of the address space
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", inst_valid, 1'b0);
        chk("async_rst_pc", inst_pc, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk); chk1("rr_c0_valid", inst_valid, 1'b0);
        next_cycle();
        @(negedge clk); chk1("rr_c1_valid", inst_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rr_c2_valid", inst_valid, 1'b1);
        chk("rr_c2_pc", inst_pc, RESET_PC);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("wrap_t3_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_t3_inst", inst, 32'h0);
        next_cycle();
        @(negedge clk);
        chk1("wrap_t4_valid", inst_valid, 1'b1);
        chk("wrap_t4_pc", inst_pc, 32'h0);
        chk("wrap_t4_inst", inst, 32'h0050_0093);
        next_cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            port_grant = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                next_cycle();
                rst_n = 1'b1;
            end else begin
                if ($urandom_range(0, 99) < 3) begin
                    redirect    = 1'b1;
                    redirect_pc = pick_target();
                end
                next_cycle();
            end
        end
        redirect = 1'b0;
        next_cycle();

        chk1("sb_activity", pops > 500, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
